// File: rtl/ipv4_pkg.sv
// rtl/ipv4_pkg.sv - IPv4 header constants, field widths and framer state type
// Shared by the IPv4 transmit and receive paths.
package ipv4_pkg;

  localparam int WORD_W     = 16;
  localparam int ADDR_W     = 32;
  localparam int PLEN_W     = 16;
  localparam int HEAD_WORDS = 10;
  localparam int HDR_BYTES  = 20;

  localparam logic [3:0]  VERSION     = 4'd4;
  localparam logic [3:0]  IHL         = 4'd5;
  localparam logic [7:0]  TOS         = 8'h00;
  localparam logic [15:0] VER_IHL_TOS = {VERSION, IHL, TOS};
  localparam logic [15:0] FLAGS_DF    = 16'h4000;
  localparam logic [7:0]  TTL_DEFAULT = 8'd64;
  localparam logic [7:0]  PROTO_UDP   = 8'd17;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_HEAD = 3'b010,
    ST_DATA = 3'b100
  } ipv4_state_e;

endpackage

// File: rtl/ipv4_checksum.sv
// rtl/ipv4_checksum.sv - combinational ones-complement checksum over N 16-bit words
// Sums into 32 bits, folds the carry twice and inverts.
module ipv4_checksum #(
  parameter int N = 9
) (
  input  logic [N*16-1:0] i_words,
  output logic [15:0]     o_csum
);

  logic [31:0] w_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = w_sum + {16'h0000, i_words[k*16 +: 16]};
    end
  end

  // The second fold cannot carry: 0xFFFF + 0xFFFF folds to at most 0xFFFF.
  assign w_fold1 = {1'b0, w_sum[15:0]} + {1'b0, w_sum[31:16]};
  assign w_fold2 = w_fold1[15:0] + {15'h0000, w_fold1[16]};
  assign o_csum  = ~w_fold2;

endmodule

// File: rtl/ipv4_tx.sv
// rtl/ipv4_tx.sv - IPv4 transmit framer: 10-word header then payload passthrough
// Optional IPV4_TX_ID_CNT_EN: per-packet incrementing identification field (else ID=0).
module ipv4_tx
  import ipv4_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          LEN_W       = 2,
  parameter logic [7:0]  PROTOCOL    = PROTO_UDP,
  parameter logic [7:0]  TTL         = TTL_DEFAULT,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1480
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cancel_i,
  input  logic              start_i,
  input  logic [15:0]       pld_len_i,
  input  logic [31:0]       src_addr_i,
  input  logic [31:0]       dst_addr_i,
  output logic              idle_o,
  output logic              ready_o,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              last_o,
  output logic              err_o
);

  ipv4_state_e r_state, w_state_nxt;
  logic [3:0]        r_hdr_cnt;
  logic [PLEN_W-1:0] r_pld_cnt, r_pld_len, r_total_len;
  logic [ADDR_W-1:0] r_src, r_dst;
  logic [15:0]       r_csum;
  logic              r_err;

  logic              w_accept, w_reject, w_done;
  logic [PLEN_W:0]   w_pld_sum;
  logic [15:0]       w_total_len, w_id_next, w_id, w_csum, w_hdr_word;

`ifdef IPV4_TX_ID_CNT_EN
  logic [15:0] r_id_cnt, r_id;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_id_cnt <= '0;
      r_id     <= '0;
    end else if (w_accept) begin
      r_id_cnt <= r_id_cnt + 16'd1;
      r_id     <= r_id_cnt;
    end
  end

  assign w_id_next = r_id_cnt;
  assign w_id      = r_id;
`else
  assign w_id_next = 16'h0000;
  assign w_id      = 16'h0000;
`endif

  assign w_total_len = 16'(HDR_BYTES) + pld_len_i;

  // Checksum is formed from the start-cycle inputs so the header needs no extra cycle.
  ipv4_checksum #(.N(HEAD_WORDS - 1)) u_csum (
    .i_words ({VER_IHL_TOS, w_total_len, w_id_next, FLAGS_DF, TTL, PROTOCOL,
               src_addr_i, dst_addr_i}),
    .o_csum  (w_csum)
  );

  assign w_pld_sum = {1'b0, r_pld_cnt} + {{(PLEN_W + 1 - LEN_W){1'b0}}, len_i};
  assign w_done    = (w_pld_sum >= {1'b0, r_pld_len});

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (pld_len_i <= MAX_PAYLOAD) begin
            w_state_nxt = ST_HEAD;
            w_accept    = 1'b1;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_HEAD: begin
        if (r_hdr_cnt == 4'(HEAD_WORDS - 1)) begin
          w_state_nxt = (r_pld_len == '0) ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (valid_i && w_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (cancel_i) begin
      w_state_nxt = ST_IDLE;
      w_accept    = 1'b0;
      w_reject    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state     <= ST_IDLE;
      r_hdr_cnt   <= '0;
      r_pld_cnt   <= '0;
      r_pld_len   <= '0;
      r_total_len <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_csum      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_reject;
      if (w_accept) begin
        r_hdr_cnt   <= '0;
        r_pld_cnt   <= '0;
        r_pld_len   <= pld_len_i;
        r_total_len <= w_total_len;
        r_src       <= src_addr_i;
        r_dst       <= dst_addr_i;
        r_csum      <= w_csum;
      end else if (r_state == ST_HEAD) begin
        r_hdr_cnt <= r_hdr_cnt + 4'd1;
      end else if (r_state == ST_DATA && valid_i) begin
        r_pld_cnt <= w_pld_sum[PLEN_W-1:0];
      end
    end
  end

  always_comb begin
    w_hdr_word = 16'h0000;
    case (r_hdr_cnt)
      4'd0: w_hdr_word = VER_IHL_TOS;
      4'd1: w_hdr_word = r_total_len;
      4'd2: w_hdr_word = w_id;
      4'd3: w_hdr_word = FLAGS_DF;
      4'd4: w_hdr_word = {TTL, PROTOCOL};
      4'd5: w_hdr_word = r_csum;
      4'd6: w_hdr_word = r_src[31:16];
      4'd7: w_hdr_word = r_src[15:0];
      4'd8: w_hdr_word = r_dst[31:16];
      4'd9: w_hdr_word = r_dst[15:0];
      default: w_hdr_word = 16'h0000;
    endcase
  end

  always_comb begin
    valid_o = 1'b0;
    data_o  = '0;
    len_o   = '0;
    last_o  = 1'b0;
    case (r_state)
      ST_HEAD: begin
        valid_o = 1'b1;
        data_o  = DATA_W'(w_hdr_word);
        len_o   = LEN_W'(2);
        last_o  = (r_hdr_cnt == 4'(HEAD_WORDS - 1)) && (r_pld_len == '0);
      end
      ST_DATA: begin
        valid_o = valid_i;
        data_o  = data_i;
        len_o   = len_i;
        last_o  = valid_i && w_done;
      end
      default: ;
    endcase
  end

  assign idle_o  = (r_state == ST_IDLE);
  assign ready_o = (r_state == ST_DATA);
  assign err_o   = r_err;

endmodule

// File: tb/tb_ipv4_tx.sv
// tb/tb_ipv4_tx.sv - directed self-checking bench for ipv4_tx
// Expected ID sequence follows IPV4_TX_ID_CNT_EN when the bench is built with it.
module tb_ipv4_tx;

`ifdef IPV4_TX_ID_CNT_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nreset, cancel_i, start_i, valid_i;
  logic [15:0] pld_len_i, data_i, data_o;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [1:0]  len_i, len_o;
  logic        idle_o, ready_o, valid_o, last_o, err_o;

  int checks = 0;
  int failures = 0;
  logic [15:0] id_next = 16'h0000;
  logic [15:0] cur_id;

  always #5 clk = ~clk;

  ipv4_tx dut (
    .clk(clk), .nreset(nreset), .cancel_i(cancel_i), .start_i(start_i),
    .pld_len_i(pld_len_i), .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i),
    .idle_o(idle_o), .ready_o(ready_o), .valid_i(valid_i), .data_i(data_i),
    .len_i(len_i), .valid_o(valid_o), .data_o(data_o), .len_o(len_o),
    .last_o(last_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [15:0] ref_csum(input logic [15:0] tl, input logic [15:0] id,
                                           input logic [31:0] s, input logic [31:0] d);
    logic [31:0] acc;
    acc = 32'h4500 + tl + id + 32'h4000 + 32'h4011 + s[31:16] + s[15:0] + d[31:16] + d[15:0];
    acc = acc[15:0] + acc[31:16];
    acc = acc[15:0] + acc[31:16];
    return ~acc[15:0];
  endfunction

  // Accept-side bookkeeping: returns the ID the framer should place in the header.
  task automatic take_id(output logic [15:0] id);
    id = id_next;
    if (ID_EN) id_next = id_next + 16'd1;
  endtask

  task automatic hdr(input logic [15:0] tl, input logic [15:0] id, input logic [31:0] s,
                     input logic [31:0] d, input logic [15:0] cs, input bit last9, input int n);
    logic [15:0] words [10];
    words = '{16'h4500, tl, id, 16'h4000, 16'h4011, cs, s[31:16], s[15:0], d[31:16], d[15:0]};
    for (int i = 0; i < n; i++) begin
      settle();
      chk($sformatf("hdr%0d_valid", i), {31'b0, valid_o}, 32'd1);
      chk($sformatf("hdr%0d_data", i), {16'b0, data_o}, {16'b0, words[i]});
      chk($sformatf("hdr%0d_len", i), {30'b0, len_o}, 32'd2);
      chk($sformatf("hdr%0d_last", i), {31'b0, last_o}, {31'b0, last9 && (i == 9)});
      chk($sformatf("hdr%0d_ready", i), {31'b0, ready_o}, 32'd0);
      step();
    end
  endtask

  initial begin
    nreset = 1'b0; cancel_i = 1'b0; start_i = 1'b0; valid_i = 1'b0;
    pld_len_i = '0; src_addr_i = '0; dst_addr_i = '0; data_i = '0; len_i = '0;
    step(); step();
    settle();
    chk("rst_idle", {31'b0, idle_o}, 32'd1);
    chk("rst_ready", {31'b0, ready_o}, 32'd0);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_last", {31'b0, last_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_data", {16'b0, data_o}, 32'd0);
    nreset = 1'b1;
    step();

    // Packet 1: 95-byte payload, reference header with checksum B861, bubble mid-payload
    start_i = 1'b1; pld_len_i = 16'd95; src_addr_i = 32'hC0A80001; dst_addr_i = 32'hC0A800C7;
    settle();
    chk("p1_idle_at_start", {31'b0, idle_o}, 32'd1);
    take_id(cur_id);
    step();
    start_i = 1'b0;
    hdr(16'h0073, 16'h0000, 32'hC0A80001, 32'hC0A800C7, 16'hB861, 1'b0, 10);
    for (int k = 0; k < 48; k++) begin
      if (k == 20) begin
        valid_i = 1'b0;
        settle();
        chk("p1_bubble_valid", {31'b0, valid_o}, 32'd0);
        chk("p1_bubble_ready", {31'b0, ready_o}, 32'd1);
        chk("p1_bubble_last", {31'b0, last_o}, 32'd0);
        step();
      end
      valid_i = 1'b1; data_i = 16'(k * 16'h0101); len_i = (k == 47) ? 2'd1 : 2'd2;
      settle();
      chk($sformatf("p1_beat%0d_valid", k), {31'b0, valid_o}, 32'd1);
      chk($sformatf("p1_beat%0d_data", k), {16'b0, data_o}, {16'b0, 16'(k * 16'h0101)});
      chk($sformatf("p1_beat%0d_last", k), {31'b0, last_o}, {31'b0, k == 47});
      step();
    end

    // Packet 2: back-to-back start right after last_o, 3-byte payload
    valid_i = 1'b0; start_i = 1'b1; pld_len_i = 16'd3;
    src_addr_i = 32'h0A000001; dst_addr_i = 32'h0A000002;
    settle();
    chk("p2_gap_valid", {31'b0, valid_o}, 32'd0);
    chk("p2_gap_idle", {31'b0, idle_o}, 32'd1);
    take_id(cur_id);
    step();
    start_i = 1'b0;
    hdr(16'h0017, cur_id, 32'h0A000001, 32'h0A000002,
        ref_csum(16'h0017, cur_id, 32'h0A000001, 32'h0A000002), 1'b0, 10);
    valid_i = 1'b1; data_i = 16'hAABB; len_i = 2'd2;
    settle();
    chk("p2_b0_data", {16'b0, data_o}, 32'h0000AABB);
    chk("p2_b0_last", {31'b0, last_o}, 32'd0);
    step();
    valid_i = 1'b0;
    settle();
    chk("p2_bubble_valid", {31'b0, valid_o}, 32'd0);
    step();
    valid_i = 1'b1; data_i = 16'hCC00; len_i = 2'd1;
    settle();
    chk("p2_b1_data", {16'b0, data_o}, 32'h0000CC00);
    chk("p2_b1_len", {30'b0, len_o}, 32'd1);
    chk("p2_b1_last", {31'b0, last_o}, 32'd1);
    step();
    data_i = 16'hDEAD; len_i = 2'd2;
    settle();
    chk("p2_extra_valid", {31'b0, valid_o}, 32'd0);
    chk("p2_extra_ready", {31'b0, ready_o}, 32'd0);
    chk("p2_extra_idle", {31'b0, idle_o}, 32'd1);
    valid_i = 1'b0;
    step();

    // Packet 3: empty payload; start held high through the header must be ignored
    start_i = 1'b1; pld_len_i = 16'd0; src_addr_i = 32'h01020304; dst_addr_i = 32'h05060708;
    take_id(cur_id);
    step();
    pld_len_i = 16'd5;
    hdr(16'h0014, cur_id, 32'h01020304, 32'h05060708,
        ref_csum(16'h0014, cur_id, 32'h01020304, 32'h05060708), 1'b1, 10);
    start_i = 1'b0;
    settle();
    chk("p3_after_valid", {31'b0, valid_o}, 32'd0);
    chk("p3_after_idle", {31'b0, idle_o}, 32'd1);
    step();

    // Oversize request rejected with a one-cycle error pulse
    start_i = 1'b1; pld_len_i = 16'd1481;
    step();
    start_i = 1'b0;
    settle();
    chk("big_err", {31'b0, err_o}, 32'd1);
    chk("big_valid", {31'b0, valid_o}, 32'd0);
    chk("big_idle", {31'b0, idle_o}, 32'd1);
    step();
    settle();
    chk("big_err_pulse", {31'b0, err_o}, 32'd0);
    chk("big_idle2", {31'b0, idle_o}, 32'd1);

    // Max payload accepted, then cancelled during header word 4
    start_i = 1'b1; pld_len_i = 16'd1480; src_addr_i = 32'hC0A80001; dst_addr_i = 32'hC0A800C7;
    take_id(cur_id);
    step();
    start_i = 1'b0;
    settle();
    chk("max_err", {31'b0, err_o}, 32'd0);
    hdr(16'h05DC, cur_id, 32'hC0A80001, 32'hC0A800C7, 16'h0000, 1'b0, 2);
    step(); step();
    cancel_i = 1'b1;
    settle();
    chk("cxl_w4_valid", {31'b0, valid_o}, 32'd1);
    chk("cxl_w4_data", {16'b0, data_o}, 32'h00004011);
    step();
    cancel_i = 1'b0;
    settle();
    chk("cxl_valid", {31'b0, valid_o}, 32'd0);
    chk("cxl_ready", {31'b0, ready_o}, 32'd0);
    chk("cxl_last", {31'b0, last_o}, 32'd0);
    chk("cxl_idle", {31'b0, idle_o}, 32'd1);

    // Clean packet after cancel
    start_i = 1'b1; pld_len_i = 16'd2; src_addr_i = 32'hAC100001; dst_addr_i = 32'hAC1000FE;
    take_id(cur_id);
    step();
    start_i = 1'b0;
    hdr(16'h0016, cur_id, 32'hAC100001, 32'hAC1000FE,
        ref_csum(16'h0016, cur_id, 32'hAC100001, 32'hAC1000FE), 1'b0, 10);
    valid_i = 1'b1; data_i = 16'h1234; len_i = 2'd2;
    settle();
    chk("p5_data", {16'b0, data_o}, 32'h00001234);
    chk("p5_last", {31'b0, last_o}, 32'd1);
    step();
    valid_i = 1'b0;

    // Reset mid-packet returns to reset values and restarts the ID sequence
    start_i = 1'b1; pld_len_i = 16'd4;
    step();
    start_i = 1'b0;
    step(); step();
    nreset = 1'b0;
    step();
    settle();
    chk("mrst_idle", {31'b0, idle_o}, 32'd1);
    chk("mrst_valid", {31'b0, valid_o}, 32'd0);
    chk("mrst_data", {16'b0, data_o}, 32'd0);
    nreset = 1'b1;
    id_next = 16'h0000;
    step();
    start_i = 1'b1; pld_len_i = 16'd0; src_addr_i = 32'hC0A80001; dst_addr_i = 32'hC0A800C7;
    take_id(cur_id);
    step();
    start_i = 1'b0;
    hdr(16'h0014, 16'h0000, 32'hC0A80001, 32'hC0A800C7, 16'hB8C0, 1'b1, 10);
    settle();
    chk("final_idle", {31'b0, idle_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
